// File: rtl/gray_monitor_pkg.sv
// Shared definitions for the Gray-code monitor: FSM state encodings and
// the width of the debug state view.
package gray_monitor_pkg;

    // IDLE waits for the first sample, TRACK follows a legal stream,
    // ERROR is terminal until Reset. Code 2'b11 is never produced and is
    // folded into ERROR by the next-state logic.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TRACK = 2'b01,
        ST_ERROR = 2'b10
    } state_t;

endpackage

// File: rtl/gray_monitor_if.sv
// Stream interface between a Gray-code source and the monitor.
// Handshake: Valid-only, no backpressure. A code on GrayIn is consumed on
// every rising Clk edge where Valid=1; with Valid=0 GrayIn is ignored.
// OutValid is a one-cycle pulse marking that BinOut reflects an accepted
// sample. State mirrors the monitor FSM for observation.
interface gray_monitor_if #(parameter int W = 3) ();
    import gray_monitor_pkg::*;

    logic          Valid;
    logic [W-1:0]  GrayIn;
    logic [W-1:0]  BinOut;
    logic          OutValid;
    logic          Locked;
    logic          Overflow;
    logic          Err;
    state_t        State;

    // Source side: drives samples, observes results.
    modport master (
        output Valid, GrayIn,
        input  BinOut, OutValid, Locked, Overflow, Err, State
    );

    // Monitor side: consumes samples, produces results.
    modport slave (
        input  Valid, GrayIn,
        output BinOut, OutValid, Locked, Overflow, Err, State
    );
endinterface

// File: rtl/gray_monitor_gray_to_bin.sv
// Combinational Gray-to-binary decoder. Binary bit i is the XOR of all
// Gray bits from i up to the MSB.
module gray_to_bin #(
    parameter int W = 3
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);
    // Each output bit is the parity of the Gray bits at and above it.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end
endmodule

// File: rtl/gray_monitor.sv
// Receive-side checker for a Gray-coded up-count stream. Decodes each
// accepted code, allows only hold or +1 (mod 2^W) steps, flags wrap as
// sticky Overflow and any illegal step or bad first code as sticky Err.
module gray_monitor
    import gray_monitor_pkg::*;
#(
    parameter int W          = 3,
    parameter bit START_ZERO = 1'b1
) (
    input  logic         Clk,
    input  logic         Reset,
    gray_monitor_if.slave bus
);
    state_t         state_q, state_nx;
    logic [W-1:0]   bin_q, bin_nx;
    logic           outv_q, outv_nx;
    logic           ovf_q, ovf_nx;
    logic           err_q, err_nx;
    logic           locked_q;
    logic [W-1:0]   bin_in;
    logic [W-1:0]   bin_inc;

    gray_to_bin #(.W(W)) u_dec (
        .gray (bus.GrayIn),
        .bin  (bin_in)
    );

    // Expected next code in the stream; wraps naturally at W bits.
    assign bin_inc = bin_q + {{(W-1){1'b0}}, 1'b1};

    // Next-state, BinOut and flag updates for the accepted sample.
    always_comb begin
        state_nx = state_q;
        bin_nx   = bin_q;
        outv_nx  = 1'b0;
        ovf_nx   = ovf_q;
        err_nx   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Valid) begin
                    if (START_ZERO && (bin_in != '0)) begin
                        state_nx = ST_ERROR;
                        err_nx   = 1'b1;
                    end else begin
                        bin_nx   = bin_in;
                        outv_nx  = 1'b1;
                        state_nx = ST_TRACK;
                    end
                end
            end
            ST_TRACK: begin
                if (bus.Valid) begin
                    if (bin_in == bin_q) begin
                        outv_nx = 1'b1;
                    end else if (bin_in == bin_inc) begin
                        bin_nx  = bin_in;
                        outv_nx = 1'b1;
                        if (bin_q == {W{1'b1}}) begin
                            ovf_nx = 1'b1;
                        end
                    end else begin
                        state_nx = ST_ERROR;
                        err_nx   = 1'b1;
                    end
                end
            end
            default: begin
                // ERROR and the unused encoding: ignore everything until Reset.
                state_nx = ST_ERROR;
            end
        endcase
    end

    // State and output registers; Reset overrides any sample on the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            bin_q    <= '0;
            outv_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_nx;
            bin_q    <= bin_nx;
            outv_q   <= outv_nx;
            ovf_q    <= ovf_nx;
            err_q    <= err_nx;
            locked_q <= (state_nx == ST_TRACK);
        end
    end

    assign bus.BinOut   = bin_q;
    assign bus.OutValid = outv_q;
    assign bus.Locked   = locked_q;
    assign bus.Overflow = ovf_q;
    assign bus.Err      = err_q;
    assign bus.State    = state_q;
endmodule

// File: tb/tb_gray_monitor.sv
// Bench for gray_monitor: two instances (START_ZERO=1 and START_ZERO=0)
// see identical stimulus; a table-driven reference model predicts every
// output after every edge.
module tb_gray_monitor;
    import gray_monitor_pkg::*;

    localparam int W = 3;
    localparam int N = 1 << W;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    gray_monitor_if #(.W(W)) bus_a ();
    gray_monitor_if #(.W(W)) bus_b ();

    gray_monitor #(.W(W), .START_ZERO(1'b1)) dut_a (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_a.slave)
    );

    gray_monitor #(.W(W), .START_ZERO(1'b0)) dut_b (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_b.slave)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 waiting for first code, 1 tracking, 2 faulted.
    int m_mode [2];
    int m_bin  [2];
    int m_outv [2];
    int m_ovf  [2];
    int m_err  [2];
    int m_sz   [2];

    function automatic logic [W-1:0] enc(input int b);
        int g;
        g = b ^ (b >> 1);
        return g[W-1:0];
    endfunction

    // Decode by searching the Gray sequence for the code.
    function automatic int dec(input logic [W-1:0] g);
        for (int b = 0; b < N; b++) begin
            if (enc(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic model_step(input int k, input logic rst, input logic v, input logic [W-1:0] g);
        int n;
        n = dec(g);
        m_outv[k] = 0;
        if (rst) begin
            m_mode[k] = 0; m_bin[k] = 0; m_ovf[k] = 0; m_err[k] = 0;
        end else if (v) begin
            if (m_mode[k] == 0) begin
                if (m_sz[k] != 0 && n != 0) begin
                    m_mode[k] = 2; m_err[k] = 1;
                end else begin
                    m_bin[k] = n; m_outv[k] = 1; m_mode[k] = 1;
                end
            end else if (m_mode[k] == 1) begin
                if (n == m_bin[k]) begin
                    m_outv[k] = 1;
                end else if (n == (m_bin[k] + 1) % N) begin
                    if (m_bin[k] == N - 1) m_ovf[k] = 1;
                    m_bin[k] = n; m_outv[k] = 1;
                end else begin
                    m_mode[k] = 2; m_err[k] = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("a.BinOut",   32'(bus_a.BinOut),   32'(m_bin[0]));
        check("a.OutValid", 32'(bus_a.OutValid), 32'(m_outv[0]));
        check("a.Locked",   32'(bus_a.Locked),   32'(m_mode[0] == 1));
        check("a.Overflow", 32'(bus_a.Overflow), 32'(m_ovf[0]));
        check("a.Err",      32'(bus_a.Err),      32'(m_err[0]));
        check("a.State",    32'(bus_a.State),    32'(m_mode[0]));
        check("b.BinOut",   32'(bus_b.BinOut),   32'(m_bin[1]));
        check("b.OutValid", 32'(bus_b.OutValid), 32'(m_outv[1]));
        check("b.Locked",   32'(bus_b.Locked),   32'(m_mode[1] == 1));
        check("b.Overflow", 32'(bus_b.Overflow), 32'(m_ovf[1]));
        check("b.Err",      32'(bus_b.Err),      32'(m_err[1]));
        check("b.State",    32'(bus_b.State),    32'(m_mode[1]));
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic v, input logic [W-1:0] g);
        Reset        = rst;
        bus_a.Valid  = v;
        bus_a.GrayIn = g;
        bus_b.Valid  = v;
        bus_b.GrayIn = g;
        @(posedge Clk);
        model_step(0, rst, v, g);
        model_step(1, rst, v, g);
        #1;
        compare_all();
    endtask

    task automatic send_bin(input int b);
        step(1'b0, 1'b1, enc(b));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        int nxt;
        logic [W-1:0] g;
        logic [W-1:0] seq [9];
        m_sz[0] = 1;
        m_sz[1] = 0;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_bin[k] = 0; m_outv[k] = 0; m_ovf[k] = 0; m_err[k] = 0;
        end
        bus_a.Valid = 1'b0; bus_a.GrayIn = '0;
        bus_b.Valid = 1'b0; bus_b.GrayIn = '0;

        // Reset state.
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 3'b101);

        // Full Gray cycle including wrap.
        seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, seq[i]);
        check("seq.Overflow", 32'(bus_a.Overflow), 32'd1);
        check("seq.BinOut",   32'(bus_a.BinOut),   32'd0);

        // Holds at bin 2.
        step(1'b1, 1'b0, '0);
        send_bin(0); send_bin(1); send_bin(2); send_bin(2); send_bin(2);
        check("hold.BinOut", 32'(bus_a.BinOut), 32'd2);

        // Illegal jump 1 -> 4, then legal codes ignored.
        step(1'b1, 1'b0, '0);
        send_bin(0); send_bin(1); send_bin(4);
        check("jump.Err", 32'(bus_a.Err), 32'd1);
        check("jump.BinOut", 32'(bus_a.BinOut), 32'd1);
        send_bin(2); send_bin(3);

        // Backward step.
        step(1'b1, 1'b0, '0);
        send_bin(0); send_bin(1); send_bin(2); send_bin(1);

        // Bad first code: instance a faults, instance b locks on 5.
        step(1'b1, 1'b0, '0);
        send_bin(5);
        check("first.a.Err",    32'(bus_a.Err),    32'd1);
        check("first.b.BinOut", 32'(bus_b.BinOut), 32'd5);
        send_bin(6); send_bin(7); send_bin(0);

        // Reset together with Valid mid-sequence.
        step(1'b1, 1'b0, '0);
        for (int b = 0; b <= 6; b++) send_bin(b);
        step(1'b1, 1'b1, enc(7));
        send_bin(0);

        // Valid low with GrayIn toggling, then a legal advance.
        step(1'b1, 1'b0, '0);
        send_bin(0); send_bin(1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, W'($urandom_range(0, N - 1)));
        send_bin(2);

        // Randomized mix of holds, advances, junk, idle cycles and resets.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (m_mode[0] == 2 && m_mode[1] == 2 && r < 25) begin
                step(1'b1, 1'(($urandom_range(0, 1))), W'($urandom_range(0, N - 1)));
            end else if (r < 3) begin
                step(1'b1, 1'b1, W'($urandom_range(0, N - 1)));
            end else if (r < 13) begin
                step(1'b0, 1'b0, W'($urandom_range(0, N - 1)));
            end else if (r < 33) begin
                step(1'b0, 1'b1, enc(m_bin[$urandom_range(0, 1)]));
            end else if (r < 42) begin
                step(1'b0, 1'b1, W'($urandom_range(0, N - 1)));
            end else begin
                nxt = (m_bin[$urandom_range(0, 1)] + 1) % N;
                g = enc(nxt);
                step(1'b0, 1'b1, g);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
